// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock frequency meter: FSM states and
// the gate-counter width derivation.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } meas_state_e;

  // Gate counter runs 0..gate_cycles-1.
  function automatic int gate_cnt_width(input int gate_cycles);
    return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/clk_meas_chan.sv
// One measured channel: synchroniser, both-edge detector, saturating edge
// counter and sticky overflow bit.
module clk_meas_chan #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             sync_bit;
  logic             edge_det;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_bit ^ prev_q;

  // prev_q tracks the synchroniser every cycle, so the value it holds on
  // entry to GATE was loaded during ARM and no spurious edge is counted.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      prev_q <= sync_bit;
      if (clr_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (en_i && edge_det) begin
        if (&cnt_q) ovf_q <= 1'b1;
        else        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/clk_freq_meter.sv
// N-channel clock presence/frequency meter: gate-window FSM, per-channel
// edge counters, latched results and a channel readout mux.
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int NUM_CH      = 10,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 100000,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EDGES   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CH-1:0]                         toggle_in,
  input  logic                                      start,
  input  logic                                      cont_en,
  output logic                                      busy,
  output logic                                      done,
  output logic [NUM_CH*CNT_W-1:0]                   count_flat,
  output logic [NUM_CH-1:0]                         alive,
  output logic [NUM_CH-1:0]                         overflow,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
  output logic [CNT_W-1:0]                          rd_count,
  output logic                                      any_alive
);

  localparam int             GW        = gate_cnt_width(GATE_CYCLES);
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);

  meas_state_e                   state_q, state_d;
  logic [GW-1:0]                 gate_cnt_q;
  logic                          busy_q, done_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  chan_cnt, count_q;
  logic [NUM_CH-1:0]             chan_ovf, alive_d, alive_q, ovf_q;
  logic                          chan_clr, chan_en;

  assign chan_clr = (state_q == ARM);
  assign chan_en  = (state_q == GATE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_meas_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .toggle_i (toggle_in[i]),
      .clr_i    (chan_clr),
      .en_i     (chan_en),
      .cnt_o    (chan_cnt[i]),
      .ovf_o    (chan_ovf[i])
    );
    assign alive_d[i] = (chan_cnt[i] >= CNT_W'(MIN_EDGES));
  end

  // NOTE: next state defaults to the current state before the case so the
  // block stays purely combinational with no inferred latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     state_d = GATE;
      GATE:    if (gate_cnt_q == GATE_LAST) state_d = LATCH;
      LATCH:   state_d = cont_en ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      alive_q    <= '0;
      ovf_q      <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == LATCH);
      if (state_q == ARM)       gate_cnt_q <= '0;
      else if (state_q == GATE) gate_cnt_q <= gate_cnt_q + 1'b1;
      if (state_q == LATCH) begin
        count_q <= chan_cnt;
        alive_q <= alive_d;
        ovf_q   <= chan_ovf;
      end
    end
  end

  always_comb begin
    rd_count = '0;
    if (int'(rd_sel) < NUM_CH) rd_count = count_q[rd_sel];
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign count_flat = count_q;
  assign alive      = alive_q;
  assign overflow   = ovf_q;
  assign any_alive  = |alive_q;

endmodule
